ping_pong_ctrl: RTL and testbench

PING_PONG_CTRL -- requirements
Module: ping_pong_ctrl

---
 rtl/ping_pong_ctrl_pkg.sv | 17 +
 rtl/ping_pong_rd_seq.sv | 69 ++++++
 rtl/ping_pong_ctrl.sv | 134 +++++++++++++
 tb/tb_ping_pong_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_ctrl_pkg.sv
// Shared types and constants for the ping-pong buffer controller.
// PING_PONG_CTRL_STATS_EN (optional) uses STATS_W and sat_inc from here.
package ping_pong_ctrl_pkg;

    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v,
                                                    input logic               en);
        sat_inc = (en && (v != '1)) ? v + STATS_W'(1) : v;
    endfunction

endpackage

// File: rtl/ping_pong_rd_seq.sv
// Read-side sequencer: walks the full half from address 0 to rd_len-1,
// issuing one buffer read per rd_ready cycle and flagging the final issue.
module ping_pong_rd_seq
    import ping_pong_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rfull,
    input  logic [AW:0]   rd_len,
    input  logic          rd_ready,
    output logic          enb,
    output logic [AW-1:0] addrb,
    output logic          rd_done,
    output logic          rd_valid,
    output logic          rd_last
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    rd_state_t   state_q, state_d;
    logic [AW:0] rd_cnt_q, rd_cnt_d;
    logic        rd_valid_q, rd_last_q;
    logic        issue, last_issue;

    always_comb begin
        issue      = (state_q == RD_BURST) && rd_ready;
        last_issue = issue && (rd_cnt_q == (rd_len - CNT_ONE));
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        case (state_q)
            RD_IDLE: begin
                if (rfull) state_d = RD_BURST;
            end
            RD_BURST: begin
                if (last_issue) begin
                    state_d  = RD_IDLE;
                    rd_cnt_d = '0;
                end else if (issue) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // rd_valid/rd_last track the buffer's one-cycle read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= issue;
            rd_last_q  <= last_issue;
        end
    end

    assign enb      = issue;
    assign addrb    = rd_cnt_q[AW-1:0];
    assign rd_done  = last_issue;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;

endmodule

// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer controller: fills one half while the other is drained.
// Define PING_PONG_CTRL_STATS_EN to add swap_cnt / stall_cnt counters.
module ping_pong_ctrl
    import ping_pong_ctrl_pkg::*;
#(
    parameter  int BIT_LENGTH = 64,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [BIT_LENGTH-1:0] wr_data,
    input  logic                  wr_flush,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [AW:0]           rd_len,
    output logic                  ena,
    output logic                  wea,
    output logic [AW-1:0]         addra,
    output logic [BIT_LENGTH-1:0] dina,
    output logic                  enb,
    output logic [AW-1:0]         addrb,
    input  logic [BIT_LENGTH-1:0] doutb,
    output logic [BIT_LENGTH-1:0] rd_data,
    output logic                  ping_pong
`ifdef PING_PONG_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]    swap_cnt,
    output logic [STATS_W-1:0]    stall_cnt
`endif
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0] wr_cnt_q, wr_cnt_d, len_q, len_d, rd_len_q, rd_len_d;
    logic        wfull_q, wfull_d, rfull_q, rfull_d, pp_q, pp_d;
    logic [AW:0] wr_cnt_inc;
    logic        accept, close, swap, rd_done;

    always_comb begin
        accept     = wr_valid && !wfull_q;
        wr_cnt_inc = wr_cnt_q + (accept ? CNT_ONE : '0);
        // a flush only closes the half if it ends up holding at least one word
        close      = !wfull_q && ((wr_cnt_inc == FULL_CNT) ||
                                  (wr_flush && (wr_cnt_inc != '0)));
        // rd_done frees the read half on the same edge the last read issues
        swap       = wfull_q && (!rfull_q || rd_done);

        wr_cnt_d = wr_cnt_q;
        len_d    = len_q;
        rd_len_d = rd_len_q;
        wfull_d  = wfull_q;
        rfull_d  = rfull_q;
        pp_d     = pp_q;
        if (swap) begin
            pp_d     = ~pp_q;
            rfull_d  = 1'b1;
            rd_len_d = len_q;
            wfull_d  = 1'b0;
            wr_cnt_d = '0;
        end else begin
            wr_cnt_d = wr_cnt_inc;
            if (rd_done) rfull_d = 1'b0;
            if (close) begin
                wfull_d = 1'b1;
                len_d   = wr_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            len_q    <= '0;
            rd_len_q <= '0;
            wfull_q  <= 1'b0;
            rfull_q  <= 1'b0;
            pp_q     <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            len_q    <= len_d;
            rd_len_q <= rd_len_d;
            wfull_q  <= wfull_d;
            rfull_q  <= rfull_d;
            pp_q     <= pp_d;
        end
    end

    ping_pong_rd_seq #(
        .AW(AW)
    ) u_rd_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .rfull    (rfull_q),
        .rd_len   (rd_len_q),
        .rd_ready (rd_ready),
        .enb      (enb),
        .addrb    (addrb),
        .rd_done  (rd_done),
        .rd_valid (rd_valid),
        .rd_last  (rd_last)
    );

    assign wr_ready  = !wfull_q;
    assign ena       = accept;
    assign wea       = accept;
    assign addra     = wr_cnt_q[AW-1:0];
    assign dina      = wr_data;
    assign rd_data   = doutb;
    assign rd_len    = rd_len_q;
    assign ping_pong = pp_q;

`ifdef PING_PONG_CTRL_STATS_EN
    logic [STATS_W-1:0] swap_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            swap_cnt_q  <= sat_inc(swap_cnt_q, swap);
            stall_cnt_q <= sat_inc(stall_cnt_q, wr_valid && wfull_q);
        end
    end

    assign swap_cnt  = swap_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl (DEPTH=4, BIT_LENGTH=8) with a dual-half RAM model
// and a word-stream scoreboard; stats checks build when PING_PONG_CTRL_STATS_EN is set.
module tb_ping_pong_ctrl;

    localparam int BL = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, wr_flush, rd_ready, rd_valid, rd_last;
    logic [BL-1:0] wr_data, dina, doutb, rd_data;
    logic [AW:0]   rd_len;
    logic          ena, wea, enb, ping_pong;
    logic [AW-1:0] addra, addrb;
`ifdef PING_PONG_CTRL_STATS_EN
    logic [15:0]   swap_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    ping_pong_ctrl #(.BIT_LENGTH(BL), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_flush(wr_flush),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_last(rd_last), .rd_len(rd_len),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb), .rd_data(rd_data),
        .ping_pong(ping_pong)
`ifdef PING_PONG_CTRL_STATS_EN
        , .swap_cnt(swap_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // external buffer: writes go to half ~ping_pong, reads to half ping_pong
    logic [BL-1:0] mem [2*D];
    always @(posedge clk) begin
        if (wea) mem[{~ping_pong, addra}] <= dina;
        if (enb) doutb <= mem[{ping_pong, addrb}];
    end

    typedef struct {
        logic [BL-1:0] d;
        logic          last;
    } ent_t;

    ent_t          exp_q[$];
    int            blen_q[$];
    int            wcnt    = 0;
    int            n_close = 0;
    logic [BL-1:0] logd[$];
    logic          logl[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // stream model: every accepted word must come back once, in order, with
    // rd_last on the word that closed its half (full or flushed)
    initial begin : cmp
        ent_t e;
        ent_t t;
        logic acc;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                logd.push_back(rd_data);
                logl.push_back(rd_last);
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 64'(rd_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 64'(rd_data), 64'(e.d));
                    check("rd_last", 64'(rd_last), 64'(e.last));
                    if (!e.last && blen_q.size() > 0)
                        check("rd_len", 64'(rd_len), 64'(blen_q[0]));
                    else if (e.last && blen_q.size() > 0)
                        void'(blen_q.pop_front());
                end
            end
            acc = wr_valid && wr_ready;
            check("ena", 64'(ena), 64'(acc));
            check("wea", 64'(wea), 64'(acc));
            if (acc) begin
                check("addra", 64'(addra), 64'(wcnt));
                check("dina", 64'(dina), 64'(wr_data));
                exp_q.push_back('{wr_data, 1'b0});
                wcnt++;
            end
            if (wcnt > 0 && (wcnt == D || (wr_flush && wr_ready))) begin
                t = exp_q.pop_back();
                t.last = 1'b1;
                exp_q.push_back(t);
                blen_q.push_back(wcnt);
                wcnt = 0;
                n_close++;
            end
            if (!rst_n) begin
                exp_q.delete();
                blen_q.delete();
                wcnt    = 0;
                n_close = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [BL-1:0] d, input logic fl);
        int k;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_flush = fl;
        k = 0;
        while (!wr_ready && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check("wr_ready_timeout", 64'(wr_ready), 64'(1));
        tick();
        wr_flush = 1'b0;
    endtask

    task automatic drain();
        int k;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || rd_valid) && k < 300) begin
            tick();
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int k;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_flush = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
        check("rst_ping_pong", 64'(ping_pong), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_last", 64'(rd_last), 64'(0));
        check("rst_rd_len", 64'(rd_len), 64'(0));
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        // single half, back-to-back
        rd_ready = 1'b1;
        base = logd.size();
        for (int i = 0; i < 4; i++) write_word(8'(8'h10 + i), 1'b0);
        wr_valid = 1'b0;
        check("t1_wr_ready_low", 64'(wr_ready), 64'(0));
        check("t1_pp_before", 64'(ping_pong), 64'(0));
        tick();
        check("t1_pp_swap", 64'(ping_pong), 64'(1));
        check("t1_rd_len", 64'(rd_len), 64'(4));
        drain();
        check("t1_count", 64'(logd.size() - base), 64'(4));
        if (logd.size() >= base + 4) begin
            check("t1_w0", 64'(logd[base]), 64'(8'h10));
            check("t1_w3", 64'(logd[base+3]), 64'(8'h13));
            check("t1_last3", 64'(logl[base+3]), 64'(1));
            check("t1_last0", 64'(logl[base]), 64'(0));
        end

        // both halves filled while the reader is held off
        rd_ready = 1'b0;
        base = logd.size();
        for (int i = 0; i < 8; i++) write_word(8'(8'h20 + i), 1'b0);
        wr_valid = 1'b0;
        check("t2_wr_ready_low", 64'(wr_ready), 64'(0));
        tick();
        tick();
        check("t2_no_read", 64'(rd_valid), 64'(0));
        drain();
        check("t2_count", 64'(logd.size() - base), 64'(8));
        if (logd.size() >= base + 8) begin
            check("t2_w0", 64'(logd[base]), 64'(8'h20));
            check("t2_w4", 64'(logd[base+4]), 64'(8'h24));
            check("t2_w7", 64'(logd[base+7]), 64'(8'h27));
            check("t2_last3", 64'(logl[base+3]), 64'(1));
        end

        // flush after two words, then flush on an empty half
        base = logd.size();
        write_word(8'h30, 1'b0);
        write_word(8'h31, 1'b0);
        wr_valid = 1'b0;
        wr_flush = 1'b1;
        tick();
        wr_flush = 1'b0;
        tick();
        check("t3_rd_len", 64'(rd_len), 64'(2));
        drain();
        check("t3_count", 64'(logd.size() - base), 64'(2));
        if (logd.size() >= base + 2) begin
            check("t3_last1", 64'(logl[base+1]), 64'(1));
            check("t3_last0", 64'(logl[base]), 64'(0));
        end
        wr_flush = 1'b1;
        tick();
        wr_flush = 1'b0;
        repeat (4) tick();
        check("t3_empty_flush_pp", 64'(ping_pong), 64'(n_close % 2));
        check("t3_empty_flush_rd", 64'(rd_valid), 64'(0));
        base = logd.size();
        write_word(8'h40, 1'b1);
        wr_valid = 1'b0;
        drain();
        check("t3_one_word_count", 64'(logd.size() - base), 64'(1));
        check("t3_pp_after", 64'(ping_pong), 64'(n_close % 2));

        // reader toggling every cycle
        rd_ready = 1'b0;
        base = logd.size();
        for (int i = 0; i < 4; i++) write_word(8'(8'h50 + i), 1'b0);
        wr_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd_ready = ~rd_ready;
            tick();
        end
        drain();
        check("t4_count", 64'(logd.size() - base), 64'(4));
        if (logd.size() >= base + 4)
            check("t4_w2", 64'(logd[base+2]), 64'(8'h52));

        // concurrent writing and gapped reading across several swaps
        base = logd.size();
        for (int i = 0; i < 12; i++) begin
            rd_ready = (i % 3 != 0);
            write_word(8'(8'h80 + i), 1'b0);
        end
        drain();
        check("t4b_count", 64'(logd.size() - base), 64'(12));

        // reset in the middle of a burst
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(8'(8'h60 + i), 1'b0);
        wr_valid = 1'b0;
        k = 0;
        while (!rd_valid && k < 20) begin
            tick();
            k++;
        end
        check("t5_saw_valid", 64'(rd_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        check("t5_rd_valid", 64'(rd_valid), 64'(0));
        check("t5_pp", 64'(ping_pong), 64'(0));
        check("t5_rd_len", 64'(rd_len), 64'(0));
        rst_n = 1'b1;
        tick();
        base = logd.size();
        for (int i = 0; i < 4; i++) write_word(8'(8'h70 + i), 1'b0);
        drain();
        check("t5_count", 64'(logd.size() - base), 64'(4));
        if (logd.size() >= base + 4) begin
            check("t5_w0", 64'(logd[base]), 64'(8'h70));
            check("t5_w3", 64'(logd[base+3]), 64'(8'h73));
            check("t5_last3", 64'(logl[base+3]), 64'(1));
        end

`ifdef PING_PONG_CTRL_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("st_swap_rst", 64'(swap_cnt), 64'(0));
        check("st_stall_rst", 64'(stall_cnt), 64'(0));
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) write_word(8'(8'h90 + i), 1'b0);
        drain();
        check("st_swap3", 64'(swap_cnt), 64'(3));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'hA0 + i), 1'b0);
        wr_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) write_word(8'(8'hA4 + i), 1'b0);
        wr_valid = 1'b1;
        repeat (5) tick();
        wr_valid = 1'b0;
        check("st_stall5", 64'(stall_cnt), 64'(5));
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
